clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-set controller and 1 Hz scheduler for the clockwork time-keeping block. It divides the system clock into the `clk_1hz` that drives the clockwork and runs a button-driven hour/minute/second edit sequence. It commits the edited time through `time_set`/`time_ow`, then restarts the 1 Hz phase so the next second is a full second long. It sits between the debounced button logic and the clockwork.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency. Must be even and ≥ 4. `HALF = CLK_HZ/2`.
- `clk`  in  1  system clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `btn_mode`  in  1  single-cycle pulse, synchronous, debounced: enter edit / advance field
- `btn_up`  in  1  single-cycle pulse: increment current field
- `btn_down`  in  1  single-cycle pulse: decrement current field
- `btn_cancel`  in  1  single-cycle pulse: abort edit without loading
- `time_cur`  in  17  live time from the clockwork, format hhhhh_mmmmmm_ssssss
- `time_set`  out  17  edit value, same format; goes to the clockwork `time_in`
- `time_ow`  out  1  overwrite strobe to the clockwork
- `clk_1hz`  out  1  1 Hz clock to the clockwork, 50 % duty
- `editing`  out  1  high in SET_H, SET_M, SET_S and LOAD
- `field`  out  2  00 none, 01 hour, 10 minute, 11 second; used for display blink

## Operation
- States: RUN, SET_H, SET_M, SET_S, LOAD. All outputs are registered.
- Reset values: state RUN, `time_set` 0, `time_ow` 0, `clk_1hz` 0, divider count 0, `editing` 0, `field` 00.
- **RUN**
  - Divider counts 0..HALF-1. At count HALF-1, `clk_1hz` toggles and the count wraps to 0.
  - `btn_mode` captures `time_cur` into the edit registers and moves to SET_H.
  - `btn_up`, `btn_down` and `btn_cancel` are ignored.
- **SET_H / SET_M / SET_S**
  - Divider count and `clk_1hz` hold their values (time frozen, no edges).
  - `btn_up` increments the field. `btn_down` decrements it.
  - Wrap rules: hour 23↔0; minute and second 59↔0. Arithmetic is done at field width (5/6 bits).
  - `btn_mode` moves SET_H→SET_M→SET_S→LOAD.
- Priority in SET states, highest first:
  - `btn_cancel`: go to RUN, no load. Divider resumes from the held count, so the clockwork loses the frozen time.
  - `btn_mode`: advance; the field is not modified that cycle.
  - `btn_up` and `btn_down` together: no change.
- **LOAD**
  - Lasts exactly one cycle, then goes to RUN.
  - On the edge entering LOAD: `time_ow`←1, `clk_1hz`←1, count←0.
  - On the edge leaving LOAD: `time_ow`←0. Counting starts from 0.
  - Button inputs are ignored in LOAD.
- `time_set` always equals the edit registers. It is stable throughout the `time_ow` high cycle.
- `field` is 01/10/11 in SET_H/SET_M/SET_S and 00 otherwise.
- Reset mid-edit: return to RUN with the reset values above. No `time_ow` is issued.

## Timing
- Any `btn_*` pulse acts on the next posedge. Input-to-output latency is 1 cycle.
- `time_ow` is high for exactly 1 clk cycle per committed edit.
- `clk_1hz` never makes a rising edge while `time_ow` is low in SET_* states, so there are no spurious increments. Its rising edge into LOAD coincides with `time_ow` high, and the clockwork's asynchronous overwrite dominates.
- Steady RUN: `clk_1hz` period is CLK_HZ cycles, HALF high and HALF low.
- After LOAD exit edge E0: `clk_1hz` falls at E0+HALF and rises at E0+CLK_HZ. The first increment after a load is therefore one full second after load.
- Resume after cancel: the remaining phase continues from the frozen count.

## Test plan
Use CLK_HZ=10 for all scenarios.
- **Reset/free run:** release `rst_n` → all outputs 0. `clk_1hz` rises at cycle 5, falls at 10, rises at 15. `editing`=0 throughout.
- **Hour wrap edit:** `time_cur`=23:58:30, then mode, up, mode, mode, mode (4 mode pulses total) → exactly one `time_ow` cycle with `time_set`=00:58:30, then `clk_1hz` rises 10 cycles after LOAD exit.
- **Minute/second down-wrap:** from 05:00:00, mode, mode, down, mode, down, mode → `time_set`=05:59:59 at `time_ow`. `field` sequence is 01, 10, 11, 00.
- **Simultaneous inputs:**
  - In SET_M, pulse up+down together → field unchanged.
  - Pulse mode+up together → moves to SET_S, minute unchanged.
  - Pulse cancel+mode together → goes to RUN, `time_ow` never asserts.
- **Freeze/cancel:** enter edit at divider count 3 with `clk_1hz`=1, hold 50 cycles, then cancel → no `clk_1hz` edges during the edit. `clk_1hz` falls 2 cycles after the RUN re-entry edge (divider reaches count HALF-1=4 and toggles).
- **Reset mid-edit:** in SET_S with edited values, assert `rst_n`=0 → immediately RUN, `time_set`=0, `time_ow`=0, `clk_1hz`=0, and no load occurs after release.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set controller and 1 Hz scheduler for the clockwork block.
// Divides clk down to clk_1hz and runs the hour/minute/second edit sequence.
module clock_set_ctrl #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_cancel,
  input  logic [16:0] time_cur,
  output logic [16:0] time_set,
  output logic        time_ow,
  output logic        clk_1hz,
  output logic        editing,
  output logic [1:0]  field
);

  localparam int HALF  = CLK_HZ / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_SET_H = 3'd1,
    S_SET_M = 3'd2,
    S_SET_S = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_hour;
  logic [5:0]       r_min;
  logic [5:0]       r_sec;
  logic             r_time_ow;
  logic             r_clk_1hz;
  logic             r_editing;
  logic [1:0]       r_field;

  logic             w_adj;
  logic [4:0]       w_hour_nxt;
  logic [5:0]       w_min_nxt;
  logic [5:0]       w_sec_nxt;

  function automatic logic [4:0] f_step_hour(input logic [4:0] v, input logic inc);
    if (inc) f_step_hour = (v == 5'd23) ? 5'd0 : v + 5'd1;
    else     f_step_hour = (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] f_step_60(input logic [5:0] v, input logic inc);
    if (inc) f_step_60 = (v == 6'd59) ? 6'd0 : v + 6'd1;
    else     f_step_60 = (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // up and down together cancel each other out
  assign w_adj      = btn_up ^ btn_down;
  assign w_hour_nxt = f_step_hour(r_hour, btn_up);
  assign w_min_nxt  = f_step_60(r_min, btn_up);
  assign w_sec_nxt  = f_step_60(r_sec, btn_up);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_hour    <= '0;
      r_min     <= '0;
      r_sec     <= '0;
      r_time_ow <= 1'b0;
      r_clk_1hz <= 1'b0;
      r_editing <= 1'b0;
      r_field   <= 2'b00;
    end else begin
      case (r_state)
        S_RUN: begin
          r_time_ow <= 1'b0;
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_clk_1hz <= ~r_clk_1hz;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (btn_mode) begin
            {r_hour, r_min, r_sec} <= time_cur;
            r_state   <= S_SET_H;
            r_editing <= 1'b1;
            r_field   <= 2'b01;
          end
        end

        // divider and clk_1hz are left untouched here so time stays frozen
        S_SET_H, S_SET_M, S_SET_S: begin
          if (btn_cancel) begin
            r_state   <= S_RUN;
            r_editing <= 1'b0;
            r_field   <= 2'b00;
          end else if (btn_mode) begin
            case (r_state)
              S_SET_H: begin
                r_state <= S_SET_M;
                r_field <= 2'b10;
              end
              S_SET_M: begin
                r_state <= S_SET_S;
                r_field <= 2'b11;
              end
              default: begin
                r_state   <= S_LOAD;
                r_field   <= 2'b00;
                r_time_ow <= 1'b1;
                r_clk_1hz <= 1'b1;
                r_cnt     <= '0;
              end
            endcase
          end else if (w_adj) begin
            case (r_state)
              S_SET_H: r_hour <= w_hour_nxt;
              S_SET_M: r_min  <= w_min_nxt;
              default: r_sec  <= w_sec_nxt;
            endcase
          end
        end

        // count held at 0 so the first fall lands HALF cycles after exit
        S_LOAD: begin
          r_state   <= S_RUN;
          r_time_ow <= 1'b0;
          r_editing <= 1'b0;
          r_field   <= 2'b00;
        end

        default: begin
          r_state   <= S_RUN;
          r_time_ow <= 1'b0;
          r_editing <= 1'b0;
          r_field   <= 2'b00;
        end
      endcase
    end
  end

  assign time_set = {r_hour, r_min, r_sec};
  assign time_ow  = r_time_ow;
  assign clk_1hz  = r_clk_1hz;
  assign editing  = r_editing;
  assign field    = r_field;

endmodule
